// File: rtl/key_lifo_ctrl_if.sv
// Handshake bundle for key_lifo_ctrl: key producer, round-key consumer and circular LIFO port.
// KEY_LIFO_CTRL_ERR_EN adds the sticky err output.
interface key_lifo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic             rk_req;
  logic [WIDTH-1:0] rk_out;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;
  logic             flush;
  logic             loaded;
  logic [WIDTH-1:0] lifo_din;
  logic             lifo_en;
  logic             lifo_r_wneg;
  logic [WIDTH-1:0] lifo_dout;
`ifdef KEY_LIFO_CTRL_ERR_EN
  logic             err;
`endif

  modport slave (
    input  key_in, key_valid, rk_req, rk_ready, flush, lifo_dout,
`ifdef KEY_LIFO_CTRL_ERR_EN
    output err,
`endif
    output key_ready, rk_out, rk_valid, rk_last, loaded, lifo_din, lifo_en, lifo_r_wneg
  );

  modport master (
    output key_in, key_valid, rk_req, rk_ready, flush, lifo_dout,
`ifdef KEY_LIFO_CTRL_ERR_EN
    input  err,
`endif
    input  key_ready, rk_out, rk_valid, rk_last, loaded, lifo_din, lifo_en, lifo_r_wneg
  );
endinterface

// File: rtl/key_lifo_ctrl.sv
// Round-key LIFO controller: loads DEPTH words, then replays them in reverse via LIFO rotation.
// Optional sticky protocol-error flag under KEY_LIFO_CTRL_ERR_EN.
module key_lifo_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  key_lifo_ctrl_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY, S_PLAY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_loaded;
  logic            w_in_load;
  logic            w_key_ready;
  logic            w_rk_valid;
  logic            w_key_hs;
  logic            w_rk_hs;
  logic [WIDTH-1:0] w_rk_out;

  // flush suppresses both handshakes so neither side sees a transfer in that cycle
  assign w_in_load   = (r_state == S_EMPTY) || (r_state == S_LOAD);
  assign w_key_ready = rst && !bus.flush && w_in_load;
  assign w_rk_valid  = rst && !bus.flush && (r_state == S_PLAY);
  assign w_key_hs    = bus.key_valid && w_key_ready;
  assign w_rk_hs     = w_rk_valid && bus.rk_ready;
  assign w_rk_out    = bus.lifo_dout;

  assign bus.key_ready   = w_key_ready;
  assign bus.rk_valid    = w_rk_valid;
  assign bus.rk_out      = w_rk_out;
  assign bus.rk_last     = w_rk_valid && (r_cnt == LAST);
  assign bus.loaded      = r_loaded;
  assign bus.lifo_din    = bus.key_in;
  assign bus.lifo_en     = w_key_hs || w_rk_hs;
  assign bus.lifo_r_wneg = w_key_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_EMPTY;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
    end else if (bus.flush) begin
      r_state  <= S_EMPTY;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_key_hs) begin
          r_state <= S_LOAD;
          r_cnt   <= CW'(1);
        end
        S_LOAD: if (w_key_hs) begin
          if (r_cnt == LAST) begin
            r_state  <= S_READY;
            r_cnt    <= '0;
            r_loaded <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_READY: if (bus.rk_req) begin
          r_state  <= S_PLAY;
          r_loaded <= 1'b0;
        end
        S_PLAY: if (w_rk_hs) begin
          // DEPTH rotations put the LIFO back in post-load order
          if (r_cnt == LAST) begin
            r_state  <= S_READY;
            r_cnt    <= '0;
            r_loaded <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LIFO_CTRL_ERR_EN
  logic r_err;
  assign bus.err = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (bus.flush)
      r_err <= 1'b0;
    else if ((bus.rk_req && r_state != S_READY) ||
             (bus.key_valid && (r_state == S_READY || r_state == S_PLAY)))
      r_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_key_lifo_ctrl.sv
// Bench for key_lifo_ctrl with a behavioural circular LIFO and a playback scoreboard.
module tb_key_lifo_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_lifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  key_lifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // circular LIFO: push inserts at top, rotate moves top to bottom
  logic [WIDTH-1:0] lifo_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (bus.lifo_en) begin
      if (bus.lifo_r_wneg) begin
        lifo_mem[0] <= bus.lifo_din;
        for (int i = 1; i < DEPTH; i++) lifo_mem[i] <= lifo_mem[i-1];
      end else begin
        for (int i = 0; i < DEPTH-1; i++) lifo_mem[i] <= lifo_mem[i+1];
        lifo_mem[DEPTH-1] <= lifo_mem[0];
      end
    end
  end
  assign bus.lifo_dout = lifo_mem[0];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } sb_t;
  sb_t sb[$];
  logic [WIDTH-1:0] exp_keys [DEPTH];

  task automatic push_playback();
    sb_t e;
    for (int i = DEPTH-1; i >= 0; i--) begin
      e.data = exp_keys[i];
      e.last = (i == 0);
      sb.push_back(e);
    end
  endtask

  // scoreboard monitor: pop on every rk handshake, check hold value on stalls
  always @(negedge clk) begin
    sb_t e;
    if (bus.rk_valid && bus.rk_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rk_out", bus.rk_out, e.data);
        chk("rk_last", {31'd0, bus.rk_last}, {31'd0, e.last});
      end
    end else if (bus.rk_valid && !bus.rk_ready && sb.size() > 0) begin
      chk("rk_hold", bus.rk_out, sb[0].data);
    end
  end

  typedef struct {
    logic             kv;
    logic [WIDTH-1:0] key;
    logic             req;
    logic             rdy;
    logic             e_kr;
    logic             e_rkv;
    logic             e_en;
    logic             e_wneg;
    logic             e_ld;
    logic             e_last;
  } vec_t;
  localparam int NV = 20;
  vec_t vec [NV];

  function automatic vec_t mk(input logic kv, input logic [WIDTH-1:0] key, input logic req,
                              input logic rdy, input logic e_kr, input logic e_rkv,
                              input logic e_en, input logic e_wneg, input logic e_ld,
                              input logic e_last);
    vec_t v;
    v.kv = kv; v.key = key; v.req = req; v.rdy = rdy;
    v.e_kr = e_kr; v.e_rkv = e_rkv; v.e_en = e_en; v.e_wneg = e_wneg;
    v.e_ld = e_ld; v.e_last = e_last;
    return v;
  endfunction

  task automatic idle();
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_req    = 1'b0;
    bus.rk_ready  = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.key_valid = 1'b1;
      bus.key_in    = base + WIDTH'(i);
      exp_keys[i]   = base + WIDTH'(i);
      @(negedge clk);
      chk("load_en", {31'd0, bus.lifo_en}, 32'd1);
      next();
    end
    bus.key_valid = 1'b0;
    @(negedge clk);
    chk("loaded_after_load", {31'd0, bus.loaded}, 32'd1);
    next();
  endtask

  // mode 0: rk_ready always 1; mode 1: rk_ready pattern 1,0,0 repeating
  task automatic play(input int mode);
    int   n;
    logic rdy;
    n = 0;
    bus.rk_req = 1'b1;
    push_playback();
    next();
    bus.rk_req = 1'b0;
    while (sb.size() > 0 && n < 64) begin
      rdy = (mode == 0) ? 1'b1 : (n % 3 == 0);
      bus.rk_ready = rdy;
      @(negedge clk);
      if (mode == 1) chk("stall_en", {31'd0, bus.lifo_en}, {31'd0, rdy});
      next();
      n++;
    end
    bus.rk_ready = 1'b0;
    chk("play_remaining", sb.size(), 32'd0);
    @(negedge clk);
    chk("loaded_after_play", {31'd0, bus.loaded}, 32'd1);
    chk("rkv_after_play", {31'd0, bus.rk_valid}, 32'd0);
    next();
  endtask

  initial begin
    vec[0] = mk(0, 32'h0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++)
      vec[i] = mk(1, WIDTH'(i-1), (i == 4), 0, 1, 0, 1, 1, 0, 0);
    vec[9]  = mk(1, 32'h55, 0, 0, 0, 0, 0, 0, 1, 0);
    vec[10] = mk(0, 32'h0, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 11; i <= 18; i++)
      vec[i] = mk((i == 12), 32'h99, 0, 1, 0, 1, 1, 0, 0, (i == 18));
    vec[19] = mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0);

    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lifo_en", {31'd0, bus.lifo_en}, 32'd0);
    chk("rst_loaded", {31'd0, bus.loaded}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_key_ready", {31'd0, bus.key_ready}, 32'd1);
    chk("post_rst_rk_valid", {31'd0, bus.rk_valid}, 32'd0);
    chk("post_rst_rk_last", {31'd0, bus.rk_last}, 32'd0);
    next();

    // table: ignored rk_req in EMPTY, load with concurrent rk_req, ignored key in READY/PLAY, playback
    begin
      int nk;
      nk = 0;
      for (int i = 0; i < NV; i++) begin
        bus.key_valid = vec[i].kv;
        bus.key_in    = vec[i].key;
        bus.rk_req    = vec[i].req;
        bus.rk_ready  = vec[i].rdy;
        if (vec[i].kv && vec[i].e_kr) begin
          exp_keys[nk] = vec[i].key;
          nk++;
        end
        if (vec[i].req && vec[i].e_ld) push_playback();
        @(negedge clk);
        chk($sformatf("v%0d_key_ready", i), {31'd0, bus.key_ready}, {31'd0, vec[i].e_kr});
        chk($sformatf("v%0d_rk_valid", i), {31'd0, bus.rk_valid}, {31'd0, vec[i].e_rkv});
        chk($sformatf("v%0d_lifo_en", i), {31'd0, bus.lifo_en}, {31'd0, vec[i].e_en});
        if (vec[i].e_en)
          chk($sformatf("v%0d_wneg", i), {31'd0, bus.lifo_r_wneg}, {31'd0, vec[i].e_wneg});
        if (vec[i].e_en && vec[i].e_wneg)
          chk($sformatf("v%0d_din", i), bus.lifo_din, vec[i].key);
        chk($sformatf("v%0d_loaded", i), {31'd0, bus.loaded}, {31'd0, vec[i].e_ld});
        chk($sformatf("v%0d_rk_last", i), {31'd0, bus.rk_last}, {31'd0, vec[i].e_last});
        next();
      end
      idle();
      chk("table_remaining", sb.size(), 32'd0);
    end

    // replay without reload, then with stalls
    play(0);
    play(1);

    // flush after third word of a playback
    bus.rk_req = 1'b1;
    push_playback();
    next();
    bus.rk_req   = 1'b0;
    bus.rk_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      next();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_lifo_en", {31'd0, bus.lifo_en}, 32'd0);
    chk("flush_rk_valid", {31'd0, bus.rk_valid}, 32'd0);
    chk("flush_remaining", sb.size(), 32'd5);
    next();
    idle();
    sb.delete();
    @(negedge clk);
    chk("post_flush_key_ready", {31'd0, bus.key_ready}, 32'd1);
    chk("post_flush_loaded", {31'd0, bus.loaded}, 32'd0);
    next();
    load(32'hA0);
    play(0);

    // reset in the middle of a load
    for (int i = 0; i < 4; i++) begin
      bus.key_valid = 1'b1;
      bus.key_in    = 32'hB0 + 32'(i);
      next();
    end
    rst = 1'b0;
    #1;
    chk("midrst_lifo_en", {31'd0, bus.lifo_en}, 32'd0);
    chk("midrst_rk_valid", {31'd0, bus.rk_valid}, 32'd0);
    chk("midrst_rk_last", {31'd0, bus.rk_last}, 32'd0);
    chk("midrst_loaded", {31'd0, bus.loaded}, 32'd0);
    idle();
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_key_ready", {31'd0, bus.key_ready}, 32'd1);
    next();
    load(32'h10);
    play(0);

`ifdef KEY_LIFO_CTRL_ERR_EN
    bus.flush = 1'b1;
    next();
    idle();
    @(negedge clk);
    chk("err_clear0", {31'd0, bus.err}, 32'd0);
    next();
    bus.rk_req = 1'b1;
    next();
    bus.rk_req = 1'b0;
    @(negedge clk);
    chk("err_set", {31'd0, bus.err}, 32'd1);
    chk("err_stay_empty", {31'd0, bus.key_ready}, 32'd1);
    chk("err_not_loaded", {31'd0, bus.loaded}, 32'd0);
    next();
    bus.flush = 1'b1;
    next();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("err_flush", {31'd0, bus.err}, 32'd0);
    next();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/key_lifo_ctrl.md
KEY_LIFO_CTRL -- requirements
Module: key_lifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, round-key word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of words held by the attached circular LIFO; legal range DEPTH >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_in  input  WIDTH  word from the key-expansion producer.
REQ-006 SHALL have port key_valid  input  1  key_in valid.
REQ-007 SHALL have port key_ready  output  1  controller accepts key_in.
REQ-008 SHALL have port rk_req  input  1  single-cycle request to start a reverse-order playback.
REQ-009 SHALL have port rk_out  output  WIDTH  round-key word to the consumer.
REQ-010 SHALL have port rk_valid  output  1  rk_out valid.
REQ-011 SHALL have port rk_ready  input  1  consumer accepts rk_out.
REQ-012 SHALL have port rk_last  output  1  current rk_out is the final word of the playback.
REQ-013 SHALL have port flush  input  1  discard stored keys and return to EMPTY.
REQ-014 SHALL have port loaded  output  1  DEPTH words stored and no playback in progress.
REQ-015 SHALL have ports lifo_din (output, WIDTH), lifo_en (output, 1), lifo_r_wneg (output, 1) and lifo_dout (input, WIDTH), connecting to the circular LIFO; in that LIFO, r_wneg=1 pushes and r_wneg=0 rotates one word out.

Function
REQ-016 SHALL implement FSM states EMPTY, LOAD, READY and PLAY, plus a word counter cnt of width $clog2(DEPTH+1).
- EMPTY: key_ready=1. A key handshake moves the FSM to LOAD with cnt=1.
- LOAD: key_ready=1. Each key handshake increments cnt. The handshake that brings cnt to DEPTH moves the FSM to READY with cnt=0.
- READY: rk_req moves the FSM to PLAY.
- PLAY: each rk handshake increments cnt. The handshake made while cnt==DEPTH-1 moves the FSM to READY with cnt=0.
REQ-017 On every key handshake (key_valid & key_ready), the controller SHALL drive lifo_en=1, lifo_r_wneg=1 and lifo_din=key_in in the same cycle.
REQ-018 In PLAY, the controller SHALL drive rk_valid=1 and rk_out=lifo_dout, with zero combinational latency.
- On an rk handshake it SHALL drive lifo_en=1 and lifo_r_wneg=0.
- rk_out SHALL hold stable while rk_ready=0.
REQ-019 Playback order SHALL be the reverse of load order: after loading k0..k(DEPTH-1), the words SHALL appear as k(DEPTH-1) down to k0.
REQ-020 After exactly DEPTH rotations, the LIFO SHALL be back in its post-load order, so repeated playbacks return identical sequences without a reload.
REQ-021 rk_last SHALL equal rk_valid & (cnt==DEPTH-1).
REQ-022 In every state other than the one that owns a given handshake:
- key_ready, rk_valid and lifo_en SHALL be 0.
- rk_req outside READY SHALL be ignored.
- key_valid in READY or PLAY SHALL be ignored.
REQ-023 flush SHALL have priority over every handshake in the same cycle.
- It moves the FSM to EMPTY and sets cnt=0.
- lifo_en SHALL be 0 in that cycle.
- Legal in any state, including mid-LOAD and mid-PLAY. A rotation left misaligned by a mid-PLAY flush is corrected because the next load overwrites all DEPTH words.
REQ-024 loaded SHALL be 1 exactly when the state is READY.
REQ-025 A key handshake while rk_req is asserted SHALL be processed as a key handshake only; rk_req is not queued.

Reset
REQ-026 Asserting rst=0 SHALL immediately force:
- state EMPTY, cnt=0;
- rk_valid=0, rk_last=0, loaded=0, lifo_en=0;
- key_ready=1 once reset is released.
REQ-027 A reset asserted mid-LOAD or mid-PLAY SHALL abandon the operation; no LIFO write occurs while rst=0.

Configuration
REQ-028 Macro KEY_LIFO_CTRL_ERR_EN controls a sticky error output.
- When defined: the block SHALL add output err (1 bit). err is set to 1 on rk_req outside READY, or on key_valid in READY or PLAY. It is cleared only by reset or flush, and reset value is 0.
- When undefined: port err and its logic SHALL be absent, and behaviour is otherwise identical.

Verification (WIDTH=32, DEPTH=8)
REQ-029 Load 8 words 0x0..0x7 back-to-back, then pulse rk_req with rk_ready=1 -> rk_out = 7,6,...,0 on consecutive cycles; rk_last high only with 0x0; loaded=1 afterwards.
REQ-030 Run a second rk_req playback with no reload -> identical sequence 7..0.
REQ-031 Play with rk_ready toggled 1,0,0,1,... -> rk_out holds during stall cycles; lifo_en=1 only on handshake cycles; still 8 words total.
REQ-032 Assert flush after the 3rd word of a playback, then load 0xA0..0xA7 and play -> output 0xA7..0xA0; no lifo_en in the flush cycle.
REQ-033 Assert rst=0 mid-LOAD after 4 words -> all outputs reach reset values without a clock edge; a subsequent full load and playback is correct.
REQ-034 With KEY_LIFO_CTRL_ERR_EN defined, pulse rk_req in EMPTY -> err=1 and FSM stays EMPTY; flush -> err=0.
